mem_arbiter: RTL
================

# mem_arbiter

Arbitrates a single-ported unified memory between the instruction-fetch port and the data-memory port of the pipelined core. One transaction is in flight at a time. Data accesses have priority, and a starvation counter guarantees forward progress for fetch. The block sits between the fetch/MEM stages and the memory array. It supplies per-port grant and read-valid handshakes, which the hazard logic uses to drive stallF and stall/flush of the later stages.

## Interface
- DATA_WIDTH, 32, data/instruction word width
- ADDR_WIDTH, 32, address width
- MEM_LATENCY, 2, cycles from read issue (mem_en, !mem_we) to mem_rdata valid; legal range ≥1
- STARVE_LIMIT, 4, consecutive denied fetch-request cycles after which fetch takes priority; legal range ≥1

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request; held with if_addr until if_rvalid
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid this cycle
- if_rdata  out  DATA_WIDTH  instruction word
- dm_req  in  1  data request; held with dm_* until completion (write: dm_gnt; read: dm_rvalid)
- dm_we  in  1  1 = store, 0 = load
- dm_addrmode  in  1  0 = word, 1 = byte; passed through to memory
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  dm_rdata valid this cycle
- dm_rdata  out  DATA_WIDTH  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addrmode  out  1  access size to memory
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after read issue

## Operation
- FSM states: IDLE, RD_IF, RD_DM.
- Grants are issued only in IDLE. The grant is combinational from the requests in that cycle; mem_* are driven in the same cycle as the grant.
- Winner selection in IDLE:
  - fetch wins if if_req && (!dm_req || starve_cnt == STARVE_LIMIT);
  - otherwise data wins if dm_req.
- Granted data write: mem_en = 1, mem_we = 1, dm_gnt = 1. The write completes in that cycle and the FSM stays in IDLE. No rvalid is generated.
- Granted read:
  - mem_en = 1, mem_we = 0, plus the corresponding gnt;
  - lat_cnt loads MEM_LATENCY−1;
  - the FSM goes to RD_IF or RD_DM.
- RD_x:
  - lat_cnt decrements each cycle;
  - when lat_cnt == 0, x_rvalid = 1 with x_rdata = mem_rdata (passthrough);
  - the FSM returns to IDLE at the next edge.
- In RD_x and in its rvalid cycle, all gnt outputs are 0 and mem_en = 0. Requests are ignored. A requester presents its next request in the cycle after rvalid.
- When mem_en = 0, mem_we = 0 and mem_addr/mem_wdata/mem_addrmode are don't-care. When not valid, if_rdata/dm_rdata are don't-care.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) on each cycle with if_req && !if_gnt;
  - clears on if_gnt or when if_req = 0.
- Fetch never writes. mem_addrmode = 0 for fetch accesses.

## Timing
- Reset (rst = 0, asynchronous): FSM = IDLE, lat_cnt = 0, starve_cnt = 0. All gnt, rvalid, mem_en and mem_we are 0 while reset is asserted.
- Reset mid-read: the outstanding read is abandoned and no rvalid is ever produced for it.
- Read latency: rvalid is asserted exactly MEM_LATENCY cycles after the grant cycle. Back-to-back reads cost MEM_LATENCY+1 cycles each.
- Writes: 1 cycle each. Consecutive writes can be granted on every cycle.
- Simultaneous if_req and dm_req in IDLE: data wins unless starve_cnt == STARVE_LIMIT. The winner's counter state updates at the same edge as the grant.
- starve_cnt reaches STARVE_LIMIT after STARVE_LIMIT denied cycles. The fetch grant happens on the following IDLE cycle.
- MEM_LATENCY = 1: the rvalid cycle is the cycle immediately after the grant, and the FSM spends one cycle in RD_x.

## Test plan
- Reset then idle: rst low for 3 cycles, then high with no requests. All gnt/rvalid/mem_en = 0. Assert rst low mid-RD_DM: no dm_rvalid follows.
- Single fetch: if_req, if_addr = 0xBFC00000, mem_rdata = 0x00500513 at issue+2. Expected: if_gnt at T0, if_rvalid with if_rdata = 0x00500513 at T0+2, next grant possible at T0+3.
- Store then load: dm_we = 1, addr 0x10000, wdata 0xDEADBEEF → dm_gnt with mem_we = 1 in the same cycle. Next-cycle load of 0x10000 → dm_gnt, and dm_rvalid 2 cycles later with the memory-model value.
- Contention: if_req and dm_req (reads) held continuously with STARVE_LIMIT = 4. The data port is granted repeatedly; fetch is granted on the first IDLE after 4 denied cycles, then starve_cnt clears.
- Byte store: dm_addrmode = 1, dm_addr = 0x10003, dm_wdata = 0x000000AB. Expected: mem_addrmode = 1 and mem_addr = 0x10003 during the grant.
- MEM_LATENCY = 1 build: back-to-back fetches at 0x0, 0x4, 0x8. Expected: grants at T0, T2, T4 and rvalids at T1, T3, T5.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and
// data access. One transaction in flight at a time. Data has priority, but a
// starvation counter forces a fetch grant after enough denied cycles.
module mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // fetch port
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  // data port
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic                  dm_addrmode_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  // memory side
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic                  mem_addrmode_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_DM} state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [STV_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               fetch_wins;

  // Read data is a passthrough; it is only meaningful while rvalid is high.
  assign if_rdata_o = mem_rdata_i;
  assign dm_rdata_o = mem_rdata_i;

  // State, latency and starvation registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Arbitration, memory strobes, read completion and starvation tracking.
  always_comb begin
    state_d        = state_q;
    lat_cnt_d      = lat_cnt_q;
    starve_cnt_d   = starve_cnt_q;
    if_gnt_o       = 1'b0;
    dm_gnt_o       = 1'b0;
    if_rvalid_o    = 1'b0;
    dm_rvalid_o    = 1'b0;
    mem_en_o       = 1'b0;
    mem_we_o       = 1'b0;
    mem_addrmode_o = 1'b0;
    mem_addr_o     = dm_addr_i;
    mem_wdata_o    = dm_wdata_i;
    fetch_wins     = if_req_i && (!dm_req_i || (starve_cnt_q == STARVE_MAX));

    unique case (state_q)
      IDLE: begin
        if (fetch_wins) begin
          // Fetch is always a word read.
          if_gnt_o   = 1'b1;
          mem_en_o   = 1'b1;
          mem_addr_o = if_addr_i;
          lat_cnt_d  = LAT_INIT;
          state_d    = RD_IF;
        end else if (dm_req_i) begin
          dm_gnt_o       = 1'b1;
          mem_en_o       = 1'b1;
          mem_we_o       = dm_we_i;
          mem_addrmode_o = dm_addrmode_i;
          // A store finishes in its grant cycle; only loads wait for data.
          if (!dm_we_i) begin
            lat_cnt_d = LAT_INIT;
            state_d   = RD_DM;
          end
        end
      end
      RD_IF, RD_DM: begin
        if (lat_cnt_q == '0) begin
          if_rvalid_o = (state_q == RD_IF);
          dm_rvalid_o = (state_q == RD_DM);
          state_d     = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Count every cycle a pending fetch is not granted, saturating.
    if (if_req_i && !if_gnt_o) begin
      if (starve_cnt_q != STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q + STV_W'(1);
      end
    end else begin
      starve_cnt_d = '0;
    end

    // Handshakes stay quiet for as long as reset is held.
    if (!rst_ni) begin
      if_gnt_o    = 1'b0;
      dm_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      dm_rvalid_o = 1'b0;
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
    end
  end

endmodule
